// File: rtl/mac_conv_ctrl.sv
// Sequencer for a single-MAC 1-D convolution: walks filter taps, issues memory reads and times the MAC enables.
// Optional stall counter output enabled by defining MAC_CONV_CTRL_STALL_CNT_EN.
module mac_conv_ctrl #(
  parameter int X_LEN = 20,
  parameter int F_LEN = 13,
  parameter int XA_W  = (X_LEN > 1) ? $clog2(X_LEN) : 1,
  parameter int FA_W  = (F_LEN > 1) ? $clog2(F_LEN) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            xmem_rd_en,
  output logic [XA_W-1:0] xmem_addr,
  output logic            fmem_rd_en,
  output logic [FA_W-1:0] fmem_addr,
  output logic            en_mult_reg,
  output logic            en_adder_reg,
  output logic            reset_accum,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XA_W-1:0] out_index
`ifdef MAC_CONV_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_RUN      = 3'd2,
    S_DRAIN0   = 3'd3,
    S_DRAIN1   = 3'd4,
    S_OUT_WAIT = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [XA_W-1:0] P_LAST   = XA_W'(X_LEN - F_LEN);
  localparam logic [FA_W-1:0] TAP_LAST = FA_W'(F_LEN - 1);

  state_t          state_q, state_d;
  logic [XA_W-1:0] p_q, p_d;
  logic [FA_W-1:0] tap_q, tap_d;
  logic            en_mult_q, en_mult_d;
  logic            en_adder_q, en_adder_d;
  logic            rd_s;

  // Next-state and output decode from the registered state.
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    tap_d       = tap_q;
    rd_s        = 1'b0;
    reset_accum = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    xmem_addr   = '0;
    fmem_addr   = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          p_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        reset_accum = 1'b1;
        tap_d       = '0;
        state_d     = S_RUN;
      end
      S_RUN: begin
        rd_s      = 1'b1;
        xmem_addr = p_q + XA_W'(tap_q);
        fmem_addr = tap_q;
        if (tap_q == TAP_LAST) begin
          state_d = S_DRAIN0;
        end else begin
          tap_d = tap_q + {{(FA_W-1){1'b0}}, 1'b1};
        end
      end
      // Two drain cycles let the last read reach the accumulator.
      S_DRAIN0: state_d = S_DRAIN1;
      S_DRAIN1: state_d = S_OUT_WAIT;
      S_OUT_WAIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (p_q == P_LAST) begin
            state_d = S_DONE;
          end else begin
            p_d     = p_q + {{(XA_W-1){1'b0}}, 1'b1};
            state_d = S_CLEAR;
          end
        end else begin
          state_d = S_OUT_WAIT;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    en_mult_d    = rd_s;
    en_adder_d   = en_mult_q;
    xmem_rd_en   = rd_s;
    fmem_rd_en   = rd_s;
    en_mult_reg  = en_mult_q;
    en_adder_reg = en_adder_q;
    busy         = (state_q != S_IDLE);
    out_index    = p_q;
  end

  // State, position, tap and enable pipeline registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      p_q        <= '0;
      tap_q      <= '0;
      en_mult_q  <= 1'b0;
      en_adder_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      tap_q      <= tap_d;
      en_mult_q  <= en_mult_d;
      en_adder_q <= en_adder_d;
    end
  end

`ifdef MAC_CONV_CTRL_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Saturating count of cycles where a result waits on the consumer.
  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start) begin
      stall_d = 16'h0000;
    end else if (out_valid && !out_ready && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'h0001;
    end else begin
      stall_d = stall_q;
    end
    stall_cycles = stall_q;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q <= 16'h0000;
    end else begin
      stall_q <= stall_d;
    end
  end
`endif

endmodule

// File: tb/tb_mac_conv_ctrl.sv
// Self-checking bench for mac_conv_ctrl: cycle-level schedule model plus a MAC/memory model with a reference convolution.
module tb_mac_conv_ctrl;
  localparam int XL = 20;
  localparam int FL = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, start, out_ready;
  logic busy, done, xmem_rd_en, fmem_rd_en, en_mult_reg, en_adder_reg, reset_accum, out_valid;
  logic [4:0] xmem_addr, out_index;
  logic [3:0] fmem_addr;
  logic start4, out_ready4;
  logic busy4, done4, xrd4, frd4, em4, ea4, ra4, ov4;
  logic [1:0] xa4, fa4, oi4;
`ifdef MAC_CONV_CTRL_STALL_CNT_EN
  logic [15:0] stall_cycles, stall4;
`endif

  mac_conv_ctrl #(.X_LEN(XL), .F_LEN(FL)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .xmem_rd_en(xmem_rd_en), .xmem_addr(xmem_addr), .fmem_rd_en(fmem_rd_en), .fmem_addr(fmem_addr),
    .en_mult_reg(en_mult_reg), .en_adder_reg(en_adder_reg), .reset_accum(reset_accum),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index)
`ifdef MAC_CONV_CTRL_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  mac_conv_ctrl #(.X_LEN(4), .F_LEN(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .busy(busy4), .done(done4),
    .xmem_rd_en(xrd4), .xmem_addr(xa4), .fmem_rd_en(frd4), .fmem_addr(fa4),
    .en_mult_reg(em4), .en_adder_reg(ea4), .reset_accum(ra4),
    .out_valid(ov4), .out_ready(out_ready4), .out_index(oi4)
`ifdef MAC_CONV_CTRL_STALL_CNT_EN
    , .stall_cycles(stall4)
`endif
  );

  int vectors = 0;
  int errors  = 0;

  logic signed [7:0]  xm [32];
  logic signed [7:0]  fm [16];
  logic signed [7:0]  xd, fd;
  logic signed [15:0] prod, acc;
  logic signed [7:0]  xm4 [4];
  logic signed [7:0]  fm4 [4];
  logic signed [7:0]  xd4, fd4;
  logic signed [15:0] prod4, acc4;

  function automatic logic signed [15:0] sat16(input int v);
    if (v > 32767) return 16'sh7FFF;
    else if (v < -32768) return 16'sh8000;
    else return 16'(v);
  endfunction

  // Synchronous memories and two-stage saturating MAC driven by the controllers.
  always_ff @(posedge clk) begin
    if (xmem_rd_en) xd <= xm[xmem_addr];
    if (fmem_rd_en) fd <= fm[fmem_addr];
    if (reset_accum) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      if (en_mult_reg) prod <= xd * fd;
      if (en_adder_reg) acc <= sat16(int'(acc) + int'(prod));
    end
    if (xrd4) xd4 <= xm4[xa4];
    if (frd4) fd4 <= fm4[fa4];
    if (ra4) begin
      prod4 <= '0;
      acc4  <= '0;
    end else begin
      if (em4) prod4 <= xd4 * fd4;
      if (ea4) acc4 <= sat16(int'(acc4) + int'(prod4));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference convolution output with per-step saturation in tap order.
  function automatic int ref_out(input int p);
    int s = 0;
    for (int k = 0; k < FL; k++) begin
      s = s + int'(xm[p + k]) * int'(fm[k]);
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
    end
    return s;
  endfunction

  // mode 0: ready tied high, 1: five stall cycles at p=2, 2: random ready.
  task automatic run_conv(input int mode, input int abort_p, input bit noise);
    int p = 0, j = 0, cyc = 1, outs = 0, stall_exp = 0, done_cyc = 0;
    bit in_done = 1'b0, fin = 1'b0, rd, em, ea, ra, ov, rdy;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 2000) begin
      if (in_done) begin
        chk("done_pulse", 32'({busy, done, out_valid}), 32'(3'b110));
        start = 1'b0;
        fin = 1'b1;
        done_cyc = cyc;
      end else begin
        ra = (j == 0);
        rd = (j >= 1 && j <= FL);
        em = (j >= 2 && j <= FL + 1);
        ea = (j >= 3 && j <= FL + 2);
        ov = (j >= FL + 3);
        chk("ctrl", 32'({busy, done, xmem_rd_en, fmem_rd_en, en_mult_reg, en_adder_reg, reset_accum, out_valid}),
            32'({1'b1, 1'b0, rd, rd, em, ea, ra, ov}));
        chk("xmem_addr", 32'(xmem_addr), rd ? 32'(p + j - 1) : 32'd0);
        chk("fmem_addr", 32'(fmem_addr), rd ? 32'(j - 1) : 32'd0);
        chk("out_index", 32'(out_index), 32'(p));
        if (j >= 1 && j <= 3) chk("accum_cleared", 32'(acc), 32'd0);
        if (ov) chk("accum_result", 32'(acc), 32'(ref_out(p)));
        if (p == abort_p && j == 5) begin
          reset_n = 1'b0;
          @(negedge clk);
          chk("abort_zero", 32'({busy, done, xmem_rd_en, fmem_rd_en, en_mult_reg, en_adder_reg,
                                  reset_accum, out_valid, xmem_addr, fmem_addr, out_index}), 32'd0);
          reset_n = 1'b1;
          return;
        end
        if (mode == 0) rdy = 1'b1;
        else if (mode == 1) rdy = !(p == 2 && j < FL + 8);
        else rdy = 1'($urandom_range(0, 1));
        out_ready = rdy;
        if (noise) start = 1'($urandom_range(0, 1));
        if (ov && !rdy) stall_exp++;
        if (ov && rdy) begin
          outs++;
          if (p == XL - FL) in_done = 1'b1;
          else begin
            p++;
            j = 0;
          end
        end else begin
          j++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("finished_in_budget", 32'(fin), 32'd1);
    chk("idle_after_done", 32'({busy, done}), 32'd0);
    chk("output_count", 32'(outs), 32'(XL - FL + 1));
    if (mode == 0) chk("done_cycle", 32'(done_cyc), 32'd137);
`ifdef MAC_CONV_CTRL_STALL_CNT_EN
    chk("stall_cycles", 32'(stall_cycles), 32'(stall_exp));
    if (mode == 1) chk("stall_five", 32'(stall_cycles), 32'd5);
`endif
  endtask

  initial begin
    int n_ov4, done4_cyc, idx4, res4, ref4;
    reset_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    start4 = 1'b0;
    out_ready4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({busy, done, xmem_rd_en, fmem_rd_en, en_mult_reg, en_adder_reg,
                              reset_accum, out_valid, xmem_addr, fmem_addr, out_index}), 32'd0);
    chk("reset_outputs4", 32'({busy4, done4, xrd4, frd4, em4, ea4, ra4, ov4, xa4, fa4, oi4}), 32'd0);
`ifdef MAC_CONV_CTRL_STALL_CNT_EN
    chk("reset_stall", 32'(stall_cycles), 32'd0);
`endif
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_in_idle", 32'({busy, out_valid}), 32'd0);

    for (int i = 0; i < 32; i++) xm[i] = (i < XL) ? 8'(i + 1) : 8'sd0;
    for (int i = 0; i < 16; i++) fm[i] = (i < FL) ? 8'sd1 : 8'sd0;
    run_conv(0, -1, 1'b0);

    for (int i = 0; i < XL; i++) xm[i] = 8'($urandom);
    for (int i = 0; i < FL; i++) fm[i] = 8'($urandom);
    run_conv(1, -1, 1'b1);
    run_conv(2, 4, 1'b0);
    run_conv(2, -1, 1'b1);

    for (int i = 0; i < XL; i++) xm[i] = 8'sd127;
    for (int i = 0; i < FL; i++) fm[i] = 8'sd127;
    run_conv(0, -1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      xm4[i] = 8'(i + 1);
      fm4[i] = 8'(i + 1);
    end
    ref4 = 0;
    for (int i = 0; i < 4; i++) ref4 += (i + 1) * (i + 1);
    n_ov4 = 0;
    done4_cyc = 0;
    idx4 = -1;
    res4 = 0;
    out_ready4 = 1'b1;
    @(negedge clk);
    start4 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ov4) begin
        n_ov4++;
        idx4 = int'(oi4);
        res4 = int'(acc4);
      end
      if (done4) begin
        done4_cyc = c + 1;
        start4 = 1'b0;
      end
      if (done4_cyc != 0 && c > done4_cyc + 1) break;
    end
    start4 = 1'b0;
    chk("single_out_count", 32'(n_ov4), 32'd1);
    chk("single_out_index", 32'(idx4), 32'd0);
    chk("single_out_value", 32'(res4), 32'(ref4));
    chk("single_done_cycle", 32'(done4_cyc), 32'd9);
    chk("single_idle", 32'({busy4, done4}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
